// File: rtl/reminder_sched.sv
`default_nettype none
// ============================================================================
// Module   : reminder_sched
// Purpose  : Sequencing controller for the LED reminder/light-show unit.
//            Watches the running time and the alarm setting, fires the
//            hourly chime and the alarm (alarm has priority), and owns the
//            snooze/stop policy.
// Ports    : CP                - system clock, rising edge
//            CR                - asynchronous reset, active-high
//            sec_tick          - one-cycle strobe, once per second
//            hour/min/sec_bcd  - current time, BCD
//            alarm_hour/min_bcd- alarm setting, BCD
//            alarm_en/chime_en - alarm armed / hourly chime enabled
//            snooze_key/stop_key - debounced single-cycle key pulses
//            start_light_hour  - chime trigger (high for one second)
//            start_light_alarm - alarm trigger (high for one second)
//            show_hour         - chime length in flash half-periods (2..24)
//            active_alarm      - alarm light show enable
//            snooze_active     - high while snoozing
//            snooze_cnt        - snoozes used in the current alarm event
// Revision : 1.0 - initial release
// ============================================================================
module reminder_sched #(
  parameter int SNOOZE_MIN = 5,
  parameter int ALARM_SEC  = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       sec_tick,
  input  logic [7:0] hour_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  input  logic [7:0] alarm_hour_bcd,
  input  logic [7:0] alarm_min_bcd,
  input  logic       alarm_en,
  input  logic       chime_en,
  input  logic       snooze_key,
  input  logic       stop_key,
  output logic       start_light_hour,
  output logic       start_light_alarm,
  output logic [4:0] show_hour,
  output logic       active_alarm,
  output logic       snooze_active,
  output logic [1:0] snooze_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHIME  = 2'd1,
    S_ALARM  = 2'd2,
    S_SNOOZE = 2'd3
  } state_t;

  localparam logic [9:0] c_snooze_load = 10'(SNOOZE_MIN * 60);
  localparam logic [7:0] c_ring_load   = 8'(ALARM_SEC);
  localparam logic [1:0] c_max_snooze  = 2'(MAX_SNOOZE);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_ring, w_ring_nxt;
  logic [9:0] r_snooze, w_snooze_nxt;
  logic [3:0] r_chime, w_chime_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic [4:0] r_show, w_show_nxt;
  logic       r_pulse_hour, w_pulse_hour_nxt;
  logic       r_pulse_alarm, w_pulse_alarm_nxt;

  function automatic logic f_bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // --------------------------------------------------------------------------
  // Match detection (only meaningful in a sec_tick cycle)
  // --------------------------------------------------------------------------
  logic w_time_ok, w_alarm_set_ok, w_top_of_min, w_hour_hit, w_alarm_hit;

  assign w_time_ok      = f_bcd_ok(hour_bcd) && (hour_bcd <= 8'h23) &&
                          f_bcd_ok(min_bcd) && f_bcd_ok(sec_bcd);
  assign w_alarm_set_ok = f_bcd_ok(alarm_hour_bcd) && (alarm_hour_bcd <= 8'h23) &&
                          f_bcd_ok(alarm_min_bcd);
  assign w_top_of_min   = (sec_bcd == 8'h00);
  assign w_hour_hit     = sec_tick && chime_en && w_time_ok &&
                          (min_bcd == 8'h00) && w_top_of_min;
  assign w_alarm_hit    = sec_tick && alarm_en && w_time_ok && w_alarm_set_ok &&
                          (hour_bcd == alarm_hour_bcd) &&
                          (min_bcd == alarm_min_bcd) && w_top_of_min;

  // 12-hour value of the current hour, with 0 shown as 12
  logic [4:0] w_hour_bin;
  logic [3:0] w_h12;

  assign w_hour_bin = ({1'b0, hour_bcd[7:4]} * 5'd10) + {1'b0, hour_bcd[3:0]};

  always_comb begin
    w_h12 = 4'd12;
    if (w_hour_bin >= 5'd12) begin
      w_h12 = 4'(w_hour_bin - 5'd12);
    end else begin
      w_h12 = w_hour_bin[3:0];
    end
    if (w_h12 == 4'd0) begin
      w_h12 = 4'd12;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_state       <= S_IDLE;
      r_ring        <= 8'd0;
      r_snooze      <= 10'd0;
      r_chime       <= 4'd0;
      r_cnt         <= 2'd0;
      r_show        <= 5'd0;
      r_pulse_hour  <= 1'b0;
      r_pulse_alarm <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ring        <= w_ring_nxt;
      r_snooze      <= w_snooze_nxt;
      r_chime       <= w_chime_nxt;
      r_cnt         <= w_cnt_nxt;
      r_show        <= w_show_nxt;
      r_pulse_hour  <= w_pulse_hour_nxt;
      r_pulse_alarm <= w_pulse_alarm_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_ring_nxt   = r_ring;
    w_snooze_nxt = r_snooze;
    w_chime_nxt  = r_chime;
    w_cnt_nxt    = r_cnt;
    w_show_nxt   = r_show;
    // A trigger pulse drops on the first tick after it rose, so the 1 Hz
    // sampler in the reminder unit sees it exactly once.
    w_pulse_hour_nxt  = r_pulse_hour && !sec_tick;
    w_pulse_alarm_nxt = r_pulse_alarm && !sec_tick;

    unique case (r_state)
      S_IDLE: begin
        if (w_alarm_hit) begin
          w_state_nxt       = S_ALARM;
          w_ring_nxt        = c_ring_load;
          w_cnt_nxt         = 2'd0;
          w_pulse_alarm_nxt = 1'b1;
        end else if (w_hour_hit) begin
          w_state_nxt      = S_CHIME;
          w_chime_nxt      = w_h12;
          w_show_nxt       = {w_h12, 1'b0};
          w_pulse_hour_nxt = 1'b1;
        end
      end

      S_CHIME: begin
        if (w_alarm_hit) begin
          w_state_nxt       = S_ALARM;
          w_ring_nxt        = c_ring_load;
          w_cnt_nxt         = 2'd0;
          w_pulse_alarm_nxt = 1'b1;
          w_pulse_hour_nxt  = 1'b0;
        end else if (sec_tick) begin
          if (r_chime <= 4'd1) begin
            w_chime_nxt = 4'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_chime_nxt = r_chime - 4'd1;
          end
        end
      end

      S_ALARM: begin
        // Keys outrank the tick, so a key landing on a tick never also
        // consumes a second of the new state's timer.
        if (!alarm_en) begin
          w_state_nxt = S_IDLE;
        end else if (stop_key) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 2'd0;
        end else if (snooze_key && (r_cnt < c_max_snooze)) begin
          w_state_nxt  = S_SNOOZE;
          w_snooze_nxt = c_snooze_load;
          w_cnt_nxt    = r_cnt + 2'd1;
        end else if (sec_tick) begin
          if (r_ring <= 8'd1) begin
            w_ring_nxt  = 8'd0;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 2'd0;
          end else begin
            w_ring_nxt = r_ring - 8'd1;
          end
        end
      end

      S_SNOOZE: begin
        if (stop_key || !alarm_en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 2'd0;
        end else if (sec_tick) begin
          if (r_snooze <= 10'd1) begin
            w_snooze_nxt      = 10'd0;
            w_state_nxt       = S_ALARM;
            w_ring_nxt        = c_ring_load;
            w_pulse_alarm_nxt = 1'b1;
          end else begin
            w_snooze_nxt = r_snooze - 10'd1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign start_light_hour  = r_pulse_hour;
  assign start_light_alarm = r_pulse_alarm;
  assign show_hour         = r_show;
  assign active_alarm      = (r_state == S_ALARM);
  assign snooze_active     = (r_state == S_SNOOZE);
  assign snooze_cnt        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reminder_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_reminder_sched
// Purpose  : Self-checking bench for reminder_sched. Directed scenarios
//            followed by randomized time jumps and key presses, every cycle
//            compared against a seconds-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reminder_sched;

  localparam int SNOOZE_MIN = 5;
  localparam int ALARM_SEC  = 60;
  localparam int MAX_SNOOZE = 3;

  localparam int M_IDLE   = 0;
  localparam int M_CHIME  = 1;
  localparam int M_ALARM  = 2;
  localparam int M_SNOOZE = 3;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       sec_tick = 1'b0;
  logic [7:0] hour_bcd = 8'h00;
  logic [7:0] min_bcd = 8'h00;
  logic [7:0] sec_bcd = 8'h00;
  logic [7:0] alarm_hour_bcd = 8'h00;
  logic [7:0] alarm_min_bcd = 8'h00;
  logic       alarm_en = 1'b0;
  logic       chime_en = 1'b0;
  logic       snooze_key = 1'b0;
  logic       stop_key = 1'b0;
  logic       start_light_hour;
  logic       start_light_alarm;
  logic [4:0] show_hour;
  logic       active_alarm;
  logic       snooze_active;
  logic [1:0] snooze_cnt;

  reminder_sched #(
    .SNOOZE_MIN (SNOOZE_MIN),
    .ALARM_SEC  (ALARM_SEC),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) u_dut (
    .CP                (CP),
    .CR                (CR),
    .sec_tick          (sec_tick),
    .hour_bcd          (hour_bcd),
    .min_bcd           (min_bcd),
    .sec_bcd           (sec_bcd),
    .alarm_hour_bcd    (alarm_hour_bcd),
    .alarm_min_bcd     (alarm_min_bcd),
    .alarm_en          (alarm_en),
    .chime_en          (chime_en),
    .snooze_key        (snooze_key),
    .stop_key          (stop_key),
    .start_light_hour  (start_light_hour),
    .start_light_alarm (start_light_alarm),
    .show_hour         (show_hour),
    .active_alarm      (active_alarm),
    .snooze_active     (snooze_active),
    .snooze_cnt        (snooze_cnt)
  );

  always #5 CP = ~CP;

  int n_checks = 0;
  int n_pass   = 0;
  int t_sec    = 0;

  // behavioural model: one countdown of whole seconds for whichever mode owns it
  int m_mode, m_left, m_cnt, m_show;
  bit m_ph, m_pa;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic int bcd2i(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [10:0] act_vec();
    return {start_light_hour, start_light_alarm, show_hour, active_alarm, snooze_active, snooze_cnt};
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [4:0] s;
    logic [1:0] c;
    s = m_show[4:0];
    c = m_cnt[1:0];
    return {m_ph, m_pa, s, (m_mode == M_ALARM), (m_mode == M_SNOOZE), c};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_cnt = 0; m_show = 0; m_ph = 0; m_pa = 0;
  endtask

  task automatic start_alarm();
    m_mode = M_ALARM; m_left = ALARM_SEC; m_cnt = 0;
  endtask

  task automatic model_step();
    int h, m, s, ah, am, h12;
    bit ok, hh, al, tick, nph, npa;
    tick = sec_tick;
    h  = bcd2i(hour_bcd);
    m  = bcd2i(min_bcd);
    s  = bcd2i(sec_bcd);
    ah = bcd2i(alarm_hour_bcd);
    am = bcd2i(alarm_min_bcd);
    ok = (h >= 0) && (h <= 23) && (m >= 0) && (s >= 0);
    hh = tick && chime_en && ok && (m == 0) && (s == 0);
    al = tick && alarm_en && ok && (h == ah) && (m == am) && (s == 0);
    nph = m_ph && !tick;
    npa = m_pa && !tick;
    case (m_mode)
      M_IDLE: begin
        if (al) begin
          start_alarm(); npa = 1;
        end else if (hh) begin
          h12 = h % 12;
          if (h12 == 0) h12 = 12;
          m_mode = M_CHIME; m_left = h12; m_show = 2 * h12; nph = 1;
        end
      end
      M_CHIME: begin
        if (al) begin
          start_alarm(); npa = 1; nph = 0;
        end else if (tick) begin
          m_left--;
          if (m_left <= 0) begin m_left = 0; m_mode = M_IDLE; end
        end
      end
      M_ALARM: begin
        if (!alarm_en) m_mode = M_IDLE;
        else if (stop_key) begin m_mode = M_IDLE; m_cnt = 0; end
        else if (snooze_key && m_cnt < MAX_SNOOZE) begin
          m_mode = M_SNOOZE; m_left = SNOOZE_MIN * 60; m_cnt++;
        end else if (tick) begin
          m_left--;
          if (m_left <= 0) begin m_left = 0; m_mode = M_IDLE; m_cnt = 0; end
        end
      end
      default: begin
        if (stop_key || !alarm_en) begin m_mode = M_IDLE; m_cnt = 0; end
        else if (tick) begin
          m_left--;
          if (m_left <= 0) begin m_mode = M_ALARM; m_left = ALARM_SEC; npa = 1; end
        end
      end
    endcase
    m_ph = nph;
    m_pa = npa;
  endtask

  task automatic cycle(input bit tick, input bit snz, input bit stp);
    sec_tick = tick; snooze_key = snz; stop_key = stp;
    @(posedge CP);
    if (CR) model_reset();
    else model_step();
    #1;
    chk("outputs", int'(act_vec()), int'(exp_vec()));
    sec_tick = 0; snooze_key = 0; stop_key = 0;
  endtask

  task automatic set_time(input int t);
    t_sec    = (t + 86400) % 86400;
    hour_bcd = i2bcd(t_sec / 3600);
    min_bcd  = i2bcd((t_sec / 60) % 60);
    sec_bcd  = i2bcd(t_sec % 60);
  endtask

  task automatic second(input int idle, input bit snz, input bit stp);
    set_time(t_sec + 1);
    cycle(1, snz, stp);
    repeat (idle) cycle(0, 0, 0);
  endtask

  task automatic seconds(input int n);
    repeat (n) second(1, 0, 0);
  endtask

  initial begin
    int r, nidle;
    bit snz, stp;
    model_reset();
    set_time(0);
    repeat (3) cycle(0, 0, 0);
    chk("reset_outs", int'(act_vec()), 0);
    CR = 0;
    cycle(0, 0, 0);

    // hourly chime at 15:00
    chime_en = 1;
    set_time(hms(14, 59, 58));
    second(2, 0, 0);
    second(0, 0, 0);
    chk("chime_pulse_rise", int'(start_light_hour), 1);
    chk("chime_show_15h", int'(show_hour), 6);
    second(0, 0, 0);
    chk("chime_pulse_fall", int'(start_light_hour), 0);
    seconds(4);

    set_time(hms(23, 59, 59)); second(0, 0, 0);
    chk("chime_show_00h", int'(show_hour), 24);
    seconds(13);
    set_time(hms(11, 59, 59)); second(0, 0, 0);
    chk("chime_show_12h", int'(show_hour), 24);
    seconds(13);
    set_time(hms(0, 59, 59)); second(0, 0, 0);
    chk("chime_show_01h", int'(show_hour), 2);
    seconds(3);

    // alarm at 07:00 beats the chime, then three snoozes
    alarm_hour_bcd = 8'h07; alarm_min_bcd = 8'h00; alarm_en = 1;
    set_time(hms(6, 59, 58));
    second(1, 0, 0);
    second(0, 0, 0);
    chk("alarm_active", int'(active_alarm), 1);
    chk("alarm_pulse", int'(start_light_alarm), 1);
    chk("alarm_no_chime", int'(start_light_hour), 0);
    for (int k = 1; k <= MAX_SNOOZE; k++) begin
      seconds(10);
      cycle(0, 1, 0);
      chk("snooze_state", int'(snooze_active), 1);
      chk("snooze_count", int'(snooze_cnt), k);
      seconds(SNOOZE_MIN * 60 - 1);
      chk("snooze_hold", int'(snooze_active), 1);
      second(0, 0, 0);
      chk("snooze_refire", int'(start_light_alarm), 1);
    end
    seconds(2);
    cycle(0, 1, 0);
    chk("snooze_limit", int'(active_alarm), 1);
    seconds(ALARM_SEC - 3);
    chk("ring_hold", int'(active_alarm), 1);
    second(0, 0, 0);
    chk("ring_timeout", int'(active_alarm), 0);
    chk("ring_timeout_cnt", int'(snooze_cnt), 0);

    // snooze on a tick, then snooze+stop together
    alarm_hour_bcd = 8'h09; alarm_min_bcd = 8'h30;
    set_time(hms(9, 29, 58));
    second(1, 0, 0); second(1, 0, 0);
    seconds(3);
    second(1, 1, 0);
    chk("tick_snooze_cnt", int'(snooze_cnt), 1);
    seconds(SNOOZE_MIN * 60 - 1);
    chk("tick_snooze_hold", int'(snooze_active), 1);
    second(0, 0, 0);
    chk("tick_snooze_refire", int'(active_alarm), 1);
    cycle(0, 1, 1);
    chk("stop_wins", int'(active_alarm) + int'(snooze_active), 0);
    chk("stop_cnt", int'(snooze_cnt), 0);

    // alarm_en dropped during snooze
    alarm_hour_bcd = 8'h10; alarm_min_bcd = 8'h00;
    set_time(hms(9, 59, 59)); second(0, 0, 0);
    chk("alarm10_active", int'(active_alarm), 1);
    cycle(0, 1, 0);
    alarm_en = 0;
    cycle(0, 0, 0);
    chk("en_drop_state", int'(snooze_active), 0);
    chk("en_drop_cnt", int'(snooze_cnt), 0);
    alarm_en = 1;
    seconds(2);

    // malformed BCD never matches
    alarm_hour_bcd = 8'h1B; alarm_min_bcd = 8'h00;
    hour_bcd = 8'h1B; min_bcd = 8'h00; sec_bcd = 8'h00;
    cycle(1, 0, 0);
    chk("bad_nibble", int'(active_alarm) + int'(start_light_hour), 0);
    alarm_hour_bcd = 8'h24; hour_bcd = 8'h24;
    cycle(1, 0, 0);
    chk("bad_hour", int'(active_alarm) + int'(start_light_hour), 0);
    alarm_hour_bcd = 8'h23; hour_bcd = 8'h23;
    cycle(1, 0, 0);
    chk("good_23h", int'(active_alarm), 1);
    cycle(0, 0, 1);
    set_time(hms(23, 0, 0));
    seconds(2);

    // asynchronous reset while the alarm pulse is high
    alarm_hour_bcd = 8'h11; alarm_min_bcd = 8'h00;
    set_time(hms(10, 59, 59)); second(0, 0, 0);
    chk("pre_rst_pulse", int'(start_light_alarm), 1);
    #3;
    CR = 1;
    #1;
    chk("async_rst", int'(act_vec()), 0);
    model_reset();
    cycle(0, 0, 0);
    CR = 0;
    seconds(5);
    chk("no_replay", int'(act_vec()), 0);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        set_time(hms($urandom_range(0, 23), 59, 58));
      end else if (r < 6) begin
        alarm_hour_bcd = i2bcd($urandom_range(0, 23));
        alarm_min_bcd  = i2bcd($urandom_range(0, 59));
        set_time(bcd2i(alarm_hour_bcd) * 3600 + bcd2i(alarm_min_bcd) * 60 - 2);
      end
      if ($urandom_range(0, 199) == 0) chime_en = ~chime_en;
      if ($urandom_range(0, 2999) == 0) alarm_en = 0;
      else if (!alarm_en && $urandom_range(0, 19) == 0) alarm_en = 1;
      snz = ($urandom_range(0, 29) == 0);
      stp = ($urandom_range(0, 1499) == 0);
      set_time(t_sec + 1);
      cycle(1, snz, stp);
      nidle = $urandom_range(0, 2);
      for (int j = 0; j < nidle; j++) begin
        snz = ($urandom_range(0, 29) == 0);
        stp = ($urandom_range(0, 1499) == 0);
        cycle(0, snz, stp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reminder_sched.md
Name: reminder_sched

Overview:
Sequencing controller for the LED reminder/light-show unit. It watches the running time and the alarm setting, and decides when to fire the hourly chime and when to fire the alarm. Alarm has priority over the chime. It owns the snooze/stop policy and drives the chime length, trigger and alarm-active inputs of the reminder unit. It sits between the time counter / alarm-set registers and the reminder LED driver.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes (1..15)
ALARM_SEC, 60, seconds the alarm rings before auto-timeout (1..255)
MAX_SNOOZE, 3, number of snoozes allowed per alarm event (1..3)

Ports:
CP  in  1  system clock; all state on rising edge
CR  in  1  asynchronous reset, active-high
sec_tick  in  1  one-CP-cycle strobe, once per second
hour_bcd  in  8  current hour, BCD 00-23
min_bcd  in  8  current minute, BCD 00-59
sec_bcd  in  8  current second, BCD 00-59
alarm_hour_bcd  in  8  alarm hour, BCD
alarm_min_bcd  in  8  alarm minute, BCD
alarm_en  in  1  alarm armed
chime_en  in  1  hourly chime enabled
snooze_key  in  1  debounced single-cycle pulse
stop_key  in  1  debounced single-cycle pulse
start_light_hour  out  1  chime trigger to reminder unit
start_light_alarm  out  1  alarm trigger to reminder unit
show_hour  out  5  chime length in flash half-periods (2..24)
active_alarm  out  1  alarm light show enable
snooze_active  out  1  high in SNOOZE
snooze_cnt  out  2  snoozes used in current alarm event

Behaviour:
- Reset (CR=1, async): state=IDLE; all outputs 0; snooze timer, ring timer and chime timer cleared.
- States: IDLE, CHIME, ALARM, SNOOZE. State is one-hot or encoded; this is an implementation choice.
- Match evaluation happens only in a cycle where sec_tick=1, using the time inputs as sampled in that cycle.
  - hour_hit = chime_en & min_bcd==00 & sec_bcd==00.
  - alarm_hit = alarm_en & hour_bcd==alarm_hour_bcd & min_bcd==alarm_min_bcd & sec_bcd==00.
  - Any BCD nibble >9, or hour >23, gives no match.
- Trigger pulses:
  - start_light_hour and start_light_alarm rise in the cycle after the triggering tick.
  - Each falls in the cycle after the next sec_tick, so it is high for exactly one second and is seen by exactly one 1 Hz sampling edge.
- show_hour = 2*h12, latched at chime trigger, where h12 = hour mod 12 and 0 maps to 12 (00h->24, 13h->2). It holds until the next chime trigger. It is 0 after reset.
- IDLE:
  - alarm_hit -> ALARM; ring timer = ALARM_SEC; snooze_cnt = 0.
  - else hour_hit -> CHIME; chime timer = show_hour/2 seconds.
  - Both hits on the same tick (e.g. alarm at 07:00): alarm wins and the chime is dropped.
- CHIME:
  - Chime timer decrements on each sec_tick; at 0 -> IDLE.
  - alarm_hit during CHIME aborts the chime -> ALARM. start_light_hour is forced low in the next cycle.
- ALARM: active_alarm=1.
  - Priority order, highest first, same cycle: CR, alarm_en=0, stop_key, snooze_key, ring timeout.
  - alarm_en=0 -> IDLE immediately.
  - stop_key -> IDLE; snooze_cnt=0.
  - snooze_key:
    - if snooze_cnt<MAX_SNOOZE: -> SNOOZE; snooze timer = SNOOZE_MIN*60; snooze_cnt += 1.
    - else ignored, stays in ALARM.
  - Ring timer decrements per sec_tick; at 0 -> IDLE; snooze_cnt=0.
  - hour_hit is ignored in ALARM.
- SNOOZE: active_alarm=0; snooze_active=1.
  - Timer decrements per sec_tick; on reaching 0 -> ALARM with a fresh start_light_alarm pulse and ring timer = ALARM_SEC.
  - stop_key or alarm_en=0 -> IDLE; snooze_cnt=0.
  - hour_hit and alarm_hit are ignored in SNOOZE.
- A key pulse coinciding with sec_tick: the key transition takes effect, and that tick does not decrement the new state's timer.
- Keys are ignored in IDLE and CHIME.
- Timers: snooze timer is 10 bits (max 900); ring timer is 8 bits. Neither wraps; they saturate at 0.
- Reset mid-operation returns to IDLE with pulses dropped in the same cycle; no trigger is replayed after release.

Test Plan:
- chime_en=1, time steps 14:59:59->15:00:00 -> start_light_hour high for exactly 1 s starting the cycle after the tick; show_hour=6; CHIME lasts 3 s then IDLE.
- Hour 00:00:00 with chime -> show_hour=24; hour 12:00:00 -> show_hour=24; hour 01:00:00 -> show_hour=2.
- alarm 07:00, both enables on, reach 07:00:00 -> ALARM, start_light_alarm 1 s, active_alarm=1, start_light_hour never asserts.
- Alarm rings, snooze_key at t=10 s -> SNOOZE, snooze_cnt=1; after 300 ticks -> ALARM re-fires. Repeat to snooze_cnt=3; a 4th snooze_key is ignored; ALARM_SEC=60 ticks later -> IDLE, snooze_cnt=0.
- snooze_key and stop_key in the same cycle during ALARM -> IDLE, snooze_cnt=0. alarm_en dropped during SNOOZE -> IDLE next cycle.
- CR pulsed while start_light_alarm is high in ALARM -> all outputs 0 asynchronously; after release, no pulse until the next match.
